image_stream_loader: RTL and testbench
======================================

# image_stream_loader

Downstream consumer of the 8-bit host FIFO (`fifo_8x2048`, `bus_clk` domain). It drains pixel bytes from the FIFO, assembles one 28×28 signed 8-bit image in on-chip RAM, and raises `init` when the image is complete. It then serves two independent synchronous read ports to the convolution engine until that engine releases the buffer for the next image.

## Interface
Parameters:
- `IMG_W`, 28, image width in pixels
- `IMG_H`, 28, image height in pixels
- `DATA_W`, 8, pixel width (two's complement)
- `ADDR_W`, 10, address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H

Ports:
- `clk`  in  1  system clock, driven from `bus_clk`
- `rst`  in  1  reset; one clock, synchronous, active-high. At top level, driven by `!user_w_write_8_open && !user_r_read_8_open`
- `fifo_dout`  in  DATA_W  FIFO read data; valid the cycle after `fifo_rd_en`
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_rd_en`  out  1  FIFO read strobe
- `load`  in  1  read enable for both read ports
- `addr1`, `addr2`  in  ADDR_W  read addresses, row-major (y·IMG_W + x)
- `data_out1`, `data_out2`  out  signed DATA_W  registered read data
- `init`  out  1  level; high while a complete image is held
- `release`  in  1  single-cycle pulse; consumer has finished with the image
- `pixel_count`  out  ADDR_W  number of pixels written for the current image

## Operation
- N = IMG_W·IMG_H = 784.
- States:
  - FILL: reset state. Accepts bytes from the FIFO.
  - READY: image complete. Read ports are active.
- FILL behaviour:
  - `fifo_rd_en = (state==FILL) && !fifo_empty && (issued < N) && !rst`. This is combinational from registered state.
  - `issued` counts read strobes. `rd_pend` is `fifo_rd_en` delayed by one cycle.
  - When `rd_pend` is high, `mem[pixel_count] <= fifo_dout` and `pixel_count` increments.
- FILL → READY: on the cycle that writes address N-1. `init` rises on the next cycle.
  - `issued` never exceeds N, so no byte of the following image is consumed.
- READY behaviour:
  - `fifo_rd_en` is 0.
  - When `load` is high, `data_out1 <= mem[addr1]` and `data_out2 <= mem[addr2]`.
  - When `load` is low, both outputs hold their values.
  - Any address ≥ N returns 0.
- READY → FILL: when `release` is high.
  - `issued`, `pixel_count` and `init` clear on the next edge.
  - RAM contents are not cleared; they are overwritten by the next image.
- `load` during FILL is ignored; the outputs hold.
- `release` during FILL is ignored.
- `load` and `release` in the same READY cycle: the read is performed on the old image, then the state changes.
- Reset values: state FILL, `init`=0, `data_out1`=`data_out2`=0, `pixel_count`=0, `issued`=0, `rd_pend`=0, so `fifo_rd_en`=0.
- Reset in the middle of a fill discards the partial image.

## Timing
- FIFO read latency is 1 cycle. The write to RAM lands on the edge after the `rd_pend` cycle.
- Sustained rate: 1 pixel per cycle while the FIFO is non-empty.
- Minimum fill time: N+1 cycles from the first `fifo_rd_en` to `init` high.
- Read ports: address and `load` at edge k → data valid after edge k+1. This is 1-cycle latency and fully pipelined, with no bubble for back-to-back reads.
- `release` at edge k → `init` low and `fifo_rd_en` eligible in cycle k+1.
- `fifo_empty` toggling mid-fill stalls the fill without losing data or duplicating writes.

## Structure
- Shared package `cnn_pkg`:
  - `IMG_W`, `IMG_H`, `IMG_PIXELS`, `PIX_W`, `ADDR_W`
  - `pixel_t`: signed [PIX_W-1:0]
  - state enum `loader_state_t` {FILL, READY}
- Sub-module `image_ram_2r1w`: one write port and two synchronous read ports with read enable. It infers distributed or block RAM, implemented as two RAM copies if needed.
- The top module holds the FSM, counters and FIFO handshake.

## Test plan
- Continuous fill: feed bytes 0..783 mod 256, FIFO never empty.
  - `fifo_rd_en` high for exactly 784 cycles.
  - `init` rises 785 cycles after the first strobe.
  - Reading addr1=0 and addr2=783 returns 0 and 15 (783 mod 256).
- Gappy FIFO: empty asserted on a random 50% of cycles.
  - Buffer contents are identical to the continuous case.
  - `pixel_count` is monotonic and never exceeds 784.
- Read ports:
  - `load`=1 with addr1=5, addr2=800 (stored value 0x85) → next cycle `data_out1`=-123 (0x85), `data_out2`=0.
  - `load`=0 → outputs hold.
- Back-pressure and release:
  - Preload 784+10 bytes → only 784 are drained and 10 remain in the FIFO.
  - Pulse `release` together with `load` → old data is returned, `init`=0 next cycle, and the remaining 10 bytes are drained to addresses 0..9.
- Reset mid-fill:
  - Assert `rst` after 300 pixels → all outputs return to reset values.
  - A fresh 784-byte image then loads correctly starting at address 0.
- Ignored inputs: `release` and `load` pulsed during FILL → no state change, `data_out` unchanged.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared image geometry, pixel type and loader state encoding for the CNN front end.
package cnn_pkg;

  localparam int IMG_W      = 28;
  localparam int IMG_H      = 28;
  localparam int IMG_PIXELS = IMG_W * IMG_H;
  localparam int PIX_W      = 8;
  localparam int ADDR_W     = 10;

  typedef logic signed [PIX_W-1:0] pixel_t;

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } loader_state_t;

endpackage

// File: rtl/image_ram_2r1w.sv
// Image buffer: one write port, two independent registered read ports sharing a read enable.
// Reads beyond the image return zero; the read registers clear on reset.
module image_ram_2r1w #(
  parameter int DEPTH  = 784,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic signed [DATA_W-1:0] wdata_i,
  input  logic                     re_i,
  input  logic [ADDR_W-1:0]        raddr1_i,
  input  logic [ADDR_W-1:0]        raddr2_i,
  output logic signed [DATA_W-1:0] rdata1_o,
  output logic signed [DATA_W-1:0] rdata2_o
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic signed [DATA_W-1:0] rdata1_q, rdata2_q;

  // Pixel write; contents are never cleared, the next image overwrites them.
  always_ff @(posedge clk) begin
    if (we_i && (waddr_i < DEPTH_A)) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Registered reads, held when the enable is low; out-of-range addresses read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else if (re_i) begin
      rdata1_q <= (raddr1_i < DEPTH_A) ? mem[raddr1_i] : '0;
      rdata2_q <= (raddr2_i < DEPTH_A) ? mem[raddr2_i] : '0;
    end
  end

  assign rdata1_o = rdata1_q;
  assign rdata2_o = rdata2_q;

endmodule

// File: rtl/image_stream_loader.sv
// Drains pixel bytes from the host FIFO into the image buffer, flags a complete image
// with init, and serves two read ports until the consumer releases the buffer.
module image_stream_loader #(
  parameter int IMG_W  = cnn_pkg::IMG_W,
  parameter int IMG_H  = cnn_pkg::IMG_H,
  parameter int DATA_W = cnn_pkg::PIX_W,
  parameter int ADDR_W = cnn_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        fifo_dout,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  input  logic                     load,
  input  logic [ADDR_W-1:0]        addr1,
  input  logic [ADDR_W-1:0]        addr2,
  output logic signed [DATA_W-1:0] data_out1,
  output logic signed [DATA_W-1:0] data_out2,
  output logic                     init,
  input  logic                     release_i,
  output logic [ADDR_W-1:0]        pixel_count
);

  import cnn_pkg::*;

  localparam int                N      = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] N_A    = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] issued_q, issued_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic              init_q, init_d;
  logic              rd_pend_q;
  logic              wr_en;
  logic              rd_port_en;

  // Strobes stop once a full image has been requested so the next image stays in the FIFO.
  assign fifo_rd_en = (state_q == FILL) && !fifo_empty && (issued_q < N_A) && !rst;
  // FIFO data arrives one cycle after the strobe; rd_pend marks that cycle.
  assign wr_en      = rd_pend_q && (state_q == FILL);
  assign rd_port_en = load && (state_q == READY);

  // Next-state logic: fill counters, completion detect and buffer release.
  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    pix_cnt_d = pix_cnt_q;
    init_d    = init_q;
    case (state_q)
      FILL: begin
        if (fifo_rd_en) begin
          issued_d = issued_q + ADDR_W'(1);
        end
        if (wr_en) begin
          pix_cnt_d = pix_cnt_q + ADDR_W'(1);
          if (pix_cnt_q == LAST_A) begin
            state_d = READY;
            init_d  = 1'b1;
          end
        end
      end
      READY: begin
        if (release_i) begin
          state_d   = FILL;
          issued_d  = '0;
          pix_cnt_d = '0;
          init_d    = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and counter registers; reset discards any partial image.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      issued_q  <= '0;
      pix_cnt_q <= '0;
      init_q    <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      pix_cnt_q <= pix_cnt_d;
      init_q    <= init_d;
      rd_pend_q <= fifo_rd_en;
    end
  end

  image_ram_2r1w #(
    .DEPTH  (N),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wr_en),
    .waddr_i  (pix_cnt_q),
    .wdata_i  (fifo_dout),
    .re_i     (rd_port_en),
    .raddr1_i (addr1),
    .raddr2_i (addr2),
    .rdata1_o (data_out1),
    .rdata2_o (data_out2)
  );

  assign init        = init_q;
  assign pixel_count = pix_cnt_q;

endmodule

// File: tb/tb_image_stream_loader.sv
// Directed bench for image_stream_loader with a behavioural FIFO model.
module tb_image_stream_loader;

  localparam int N = 784;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        fifo_dout = '0;
  logic              fifo_empty = 1'b1;
  logic              fifo_rd_en;
  logic              load;
  logic [9:0]        addr1, addr2;
  logic signed [7:0] data_out1, data_out2;
  logic              init;
  logic              release_i;
  logic [9:0]        pixel_count;

  logic [7:0] fq[$];
  bit  gappy = 1'b0;
  bit  mon_en = 1'b0;
  int  cyc = 0;
  int  strobe_total = 0;
  bit  prev_rd = 1'b0;
  int  first_cyc = 0;
  int  init_cyc = 0;
  bit  prev_init = 1'b0;
  int  viol = 0;
  int  prev_pc = 0;
  int  n_chk = 0;
  int  n_pass = 0;

  always #5 clk = ~clk;

  image_stream_loader dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_dout   (fifo_dout),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .load        (load),
    .addr1       (addr1),
    .addr2       (addr2),
    .data_out1   (data_out1),
    .data_out2   (data_out2),
    .init        (init),
    .release_i   (release_i),
    .pixel_count (pixel_count)
  );

  // FIFO model (1-cycle read latency) plus strobe bookkeeping
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      if (!prev_rd) first_cyc = cyc;
      strobe_total++;
      if (fq.size() > 0) fifo_dout <= fq.pop_front();
    end
    prev_rd = fifo_rd_en;
  end

  always @(negedge clk) begin
    fifo_empty = (fq.size() == 0) || (gappy && ($urandom_range(0, 1) == 1));
    if (init && !prev_init) init_cyc = cyc;
    prev_init = init;
    if (mon_en) begin
      if ((int'(pixel_count) < prev_pc) || (int'(pixel_count) > N)) viol++;
      prev_pc = int'(pixel_count);
    end else begin
      prev_pc = 0;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int expv(input int pat, input int i);
    logic [7:0] b;
    case (pat)
      0:       b = 8'(i);
      1:       b = 8'(i + 128);
      2:       b = (i < 10) ? 8'(160 + i) : 8'(i);
      3:       b = 8'(255 - i);
      default: b = 8'(i * 3);
    endcase
    return int'($signed(b));
  endfunction

  task automatic push_pat(input int pat, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) fq.push_back(8'(expv(pat, i)));
  endtask

  task automatic rd(input int a1, input int a2, output int o1, output int o2);
    @(negedge clk);
    addr1 = 10'(a1);
    addr2 = 10'(a2);
    load  = 1'b1;
    @(negedge clk);
    o1   = int'(data_out1);
    o2   = int'(data_out2);
    load = 1'b0;
  endtask

  task automatic check_img(input int pat);
    int o1, o2;
    for (int i = 0; i < N / 2; i++) begin
      rd(i, i + N / 2, o1, o2);
      chk($sformatf("img%0d[%0d]", pat, i), o1, expv(pat, i));
      chk($sformatf("img%0d[%0d]", pat, i + N / 2), o2, expv(pat, i + N / 2));
    end
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(init), 1);
  endtask

  task automatic pulse_release();
    @(negedge clk);
    release_i = 1'b1;
    @(negedge clk);
    release_i = 1'b0;
  endtask

  initial begin
    int o1, o2, s0, n;
    rst = 1'b1; load = 1'b0; release_i = 1'b0; addr1 = '0; addr2 = '0;

    // reset state, with data waiting in the FIFO
    push_pat(0, 0, N - 1);
    repeat (3) @(negedge clk);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    chk("rst_init", int'(init), 0);
    chk("rst_pixcnt", int'(pixel_count), 0);
    chk("rst_d1", int'(data_out1), 0);
    chk("rst_d2", int'(data_out2), 0);

    // continuous fill
    s0 = strobe_total;
    rst = 1'b0;
    wait_init("t1_init");
    repeat (3) @(negedge clk);
    chk("t1_strobes", strobe_total - s0, N);
    chk("t1_latency", init_cyc - first_cyc, N + 1);
    chk("t1_pixcnt", int'(pixel_count), N);
    rd(0, 783, o1, o2);
    chk("t1_addr0", o1, 0);
    chk("t1_addr783", o2, 15);
    check_img(0);

    // back-to-back reads
    @(negedge clk); addr1 = 10'd1; addr2 = 10'd2; load = 1'b1;
    @(negedge clk);
    chk("b2b_d1a", int'(data_out1), 1);
    chk("b2b_d2a", int'(data_out2), 2);
    addr1 = 10'd3; addr2 = 10'd4;
    @(negedge clk);
    chk("b2b_d1b", int'(data_out1), 3);
    chk("b2b_d2b", int'(data_out2), 4);
    load = 1'b0;

    // release together with load returns the old image
    @(negedge clk); addr1 = 10'd783; addr2 = 10'd10; load = 1'b1; release_i = 1'b1;
    @(negedge clk);
    chk("rel_d1", int'(data_out1), 15);
    chk("rel_d2", int'(data_out2), 10);
    chk("rel_init", int'(init), 0);
    load = 1'b0; release_i = 1'b0;

    // load and release during FILL are ignored
    @(negedge clk); addr1 = 10'd0; addr2 = 10'd0; load = 1'b1; release_i = 1'b1;
    @(negedge clk); load = 1'b0; release_i = 1'b0;
    @(negedge clk);
    chk("ign_d1", int'(data_out1), 15);
    chk("ign_d2", int'(data_out2), 10);
    chk("ign_init", int'(init), 0);
    chk("ign_pixcnt", int'(pixel_count), 0);

    // gappy FIFO
    gappy = 1'b1; mon_en = 1'b1;
    push_pat(0, 0, N - 1);
    wait_init("t2_init");
    mon_en = 1'b0; gappy = 1'b0;
    chk("t2_monotonic", viol, 0);
    chk("t2_pixcnt", int'(pixel_count), N);
    check_img(0);

    // back-pressure: 784 + 10 bytes queued
    push_pat(1, 0, N - 1);
    for (int j = 0; j < 10; j++) fq.push_back(8'(160 + j));
    s0 = strobe_total;
    pulse_release();
    wait_init("t3_init");
    repeat (5) @(negedge clk);
    chk("t3_strobes", strobe_total - s0, N);
    chk("t3_left", fq.size(), 10);
    rd(5, 800, o1, o2);
    chk("t3_addr5", o1, -123);
    chk("t3_addr800", o2, 0);
    repeat (3) @(negedge clk);
    chk("t3_hold1", int'(data_out1), -123);
    chk("t3_hold2", int'(data_out2), 0);
    @(negedge clk); addr1 = 10'd0; addr2 = 10'd9; load = 1'b1; release_i = 1'b1;
    @(negedge clk);
    chk("t3_old0", int'(data_out1), -128);
    chk("t3_old9", int'(data_out2), -119);
    chk("t3_init_low", int'(init), 0);
    load = 1'b0; release_i = 1'b0;
    n = 0;
    while (pixel_count < 10'd10 && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("t3_drain_cnt", int'(pixel_count), 10);
    chk("t3_drain_fifo", fq.size(), 0);
    push_pat(2, 10, N - 1);
    wait_init("t3b_init");
    check_img(2);

    // reset mid-fill
    push_pat(3, 0, N - 1);
    pulse_release();
    n = 0;
    while (pixel_count < 10'd300 && n < 2000) begin @(negedge clk); n++; end
    chk("t4_reach300", int'(pixel_count >= 10'd300), 1);
    rst = 1'b1;
    fq.delete();
    push_pat(4, 0, N - 1);
    @(negedge clk);
    chk("t4_rst_init", int'(init), 0);
    chk("t4_rst_pixcnt", int'(pixel_count), 0);
    chk("t4_rst_d1", int'(data_out1), 0);
    chk("t4_rst_d2", int'(data_out2), 0);
    chk("t4_rst_rd_en", int'(fifo_rd_en), 0);
    rst = 1'b0;
    wait_init("t4_init");
    chk("t4_pixcnt", int'(pixel_count), N);
    check_img(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
